// File: rtl/oled_pkg.sv
// oled_pkg: shared glyph constants, command opcodes, FSM states and glyph width lookup
package oled_pkg;
  localparam int MAX_GLYPHS = 8;
  localparam int CODE_W = 6;
  localparam logic [5:0] BLANK_MIN = 6'd15;
  localparam logic [7:0] PAGE_BASE = 8'hB0;
  localparam logic [7:0] COL_LO = 8'h00;
  localparam logic [7:0] COL_HI = 8'h10;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, LAT, SEND, DONE} state_e;
  // Codes at or above BLANK_MIN render as empty columns without touching the ROM
  function automatic logic is_blank(input logic [5:0] code);
    return code >= BLANK_MIN;
  endfunction
  function automatic logic [4:0] glyph_width(input logic [5:0] code);
    return (code inside {6'd0, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11}) ? 5'd16 : 5'd8;
  endfunction
endpackage

// File: rtl/oled_string_render.sv
// oled_string_render: turns a glyph-code list into SSD1306 page/column commands plus font data bytes
// Ports: sys_clk/rst_n (sync active-low); req_* render request (valid/ready, latched on accept);
//        font_sel/font_row/index -> font ROM, font_data <- ROM one cycle later;
//        out_valid/out_ready/out_byte/out_dc byte stream to the transport; busy, done status.
module oled_string_render
  import oled_pkg::*;
(
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_page,
  input  logic [6:0]                   req_col,
  input  logic [3:0]                   req_len,
  input  logic [CODE_W*MAX_GLYPHS-1:0] req_codes,
  output logic [5:0]                   font_sel,
  output logic                         font_row,
  output logic [8:0]                   index,
  input  logic [7:0]                   font_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_byte,
  output logic                         out_dc,
  output logic                         busy,
  output logic                         done
);
  state_e state_q, state_d;
  logic [2:0] page_q, page_d, cmd_page;
  logic [6:0] col_q, col_d;
  logic [3:0] len_q, len_d;
  logic [CODE_W*MAX_GLYPHS-1:0] codes_q, codes_d;
  logic row_q, row_d;
  logic [1:0] cmd_q, cmd_d;
  logic [2:0] k_q, k_d;
  logic [3:0] ci_q, ci_d;
  logic [7:0] scol_q, scol_d;
  logic [5:0] font_sel_q, font_sel_d;
  logic font_row_q, font_row_d;
  logic [8:0] index_q, index_d;
  logic out_valid_q, out_valid_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic out_dc_q, out_dc_d;
  logic [5:0] code, code_d;
  logic hs, last_col, row_end, row_more;
  assign code = codes_q[CODE_W*k_q +: CODE_W];
  assign hs = out_valid_q & out_ready;
  assign last_col = ({1'b0, ci_q} + 5'd1) == glyph_width(code);
  // A row ends after the last column of the last glyph, or when the screen column hits 127 (clip)
  assign row_end = (last_col && ({1'b0, k_q} + 4'd1) == len_q) || scol_q == 8'd127;
  assign row_more = !row_q && page_q != 3'd7;
  always_comb begin
    state_d = state_q;
    page_d = page_q;
    col_d = col_q;
    len_d = len_q;
    codes_d = codes_q;
    row_d = row_q;
    cmd_d = cmd_q;
    k_d = k_q;
    ci_d = ci_q;
    scol_d = scol_q;
    font_sel_d = font_sel_q;
    font_row_d = font_row_q;
    index_d = index_q;
    out_valid_d = out_valid_q;
    out_byte_d = out_byte_q;
    out_dc_d = out_dc_q;
    case (state_q)
      IDLE: if (req_valid) begin
        page_d = req_page;
        col_d = req_col;
        len_d = req_len > 4'(MAX_GLYPHS) ? 4'(MAX_GLYPHS) : req_len;
        codes_d = req_codes;
        row_d = 1'b0;
        cmd_d = 2'd0;
        k_d = 3'd0;
        ci_d = 4'd0;
        scol_d = {1'b0, req_col};
        state_d = req_len == 4'd0 ? DONE : CMD;
        out_valid_d = req_len != 4'd0;
        out_dc_d = 1'b0;
      end
      CMD: if (hs) begin
        cmd_d = cmd_q == 2'd2 ? 2'd0 : cmd_q + 2'd1;
        state_d = cmd_q == 2'd2 ? ADDR : CMD;
        out_valid_d = cmd_q != 2'd2;
      end
      ADDR: begin
        state_d = is_blank(code) ? SEND : LAT;
        out_valid_d = is_blank(code);
        out_byte_d = 8'h00;
        out_dc_d = 1'b1;
      end
      LAT: begin
        state_d = SEND;
        out_valid_d = 1'b1;
        out_byte_d = font_data;
      end
      SEND: if (hs) begin
        scol_d = scol_q + 8'd1;
        out_valid_d = 1'b0;
        if (!row_end) begin
          k_d = last_col ? k_q + 3'd1 : k_q;
          ci_d = last_col ? 4'd0 : ci_q + 4'd1;
          state_d = ADDR;
        end else if (row_more) begin
          row_d = 1'b1;
          k_d = 3'd0;
          ci_d = 4'd0;
          cmd_d = 2'd0;
          scol_d = {1'b0, col_q};
          state_d = CMD;
          out_valid_d = 1'b1;
          out_dc_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Command bytes are derived from the next-state counters so they are ready when out_valid rises
    cmd_page = page_d + {2'b0, row_d};
    if (state_d == CMD)
      out_byte_d = cmd_d == 2'd0 ? PAGE_BASE | {5'd0, cmd_page} :
                   cmd_d == 2'd1 ? COL_LO | {4'd0, col_d[3:0]} : COL_HI | {5'd0, col_d[6:4]};
    // ROM address is registered on entry to ADDR; blank glyphs leave it untouched
    code_d = codes_d[CODE_W*k_d +: CODE_W];
    if (state_d == ADDR && !is_blank(code_d)) begin
      font_sel_d = code_d;
      font_row_d = row_d;
      index_d = {5'd0, ci_d};
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      page_q <= '0;
      col_q <= '0;
      len_q <= '0;
      codes_q <= '0;
      row_q <= 1'b0;
      cmd_q <= '0;
      k_q <= '0;
      ci_q <= '0;
      scol_q <= '0;
      font_sel_q <= '0;
      font_row_q <= 1'b0;
      index_q <= '0;
      out_valid_q <= 1'b0;
      out_byte_q <= '0;
      out_dc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q <= page_d;
      col_q <= col_d;
      len_q <= len_d;
      codes_q <= codes_d;
      row_q <= row_d;
      cmd_q <= cmd_d;
      k_q <= k_d;
      ci_q <= ci_d;
      scol_q <= scol_d;
      font_sel_q <= font_sel_d;
      font_row_q <= font_row_d;
      index_q <= index_d;
      out_valid_q <= out_valid_d;
      out_byte_q <= out_byte_d;
      out_dc_q <= out_dc_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign font_sel = font_sel_q;
  assign font_row = font_row_q;
  assign index = index_q;
  assign out_valid = out_valid_q;
  assign out_byte = out_byte_q;
  assign out_dc = out_dc_q;
endmodule

// File: tb/tb_oled_string_render.sv
// tb_oled_string_render: scoreboard bench for oled_string_render with a behavioural font ROM
module tb_oled_string_render;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [2:0] req_page = '0;
  logic [6:0] req_col = '0;
  logic [3:0] req_len = '0;
  logic [47:0] req_codes = '0;
  logic req_ready;
  logic [5:0] font_sel;
  logic font_row;
  logic [8:0] index;
  logic [7:0] font_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [7:0] out_byte;
  logic out_dc, busy, done;
  int n_tests = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int stall_err, done_cyc, first_valid;
  bit font_chg, busy_at_done;
  logic [8:0] e, o;

  oled_string_render dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_page(req_page), .req_col(req_col), .req_len(req_len), .req_codes(req_codes),
    .font_sel(font_sel), .font_row(font_row), .index(index), .font_data(font_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_dc(out_dc),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] rom(input logic [5:0] s, input logic r, input logic [8:0] i);
    if (s == 6'd0 && i < 9'd4) begin
      case ({r, i[1:0]})
        3'b010: return 8'hF8;
        3'b011: return 8'h08;
        3'b110: return 8'h7F;
        3'b100, 3'b101, 3'b111: return 8'h40;
        default: return 8'h00;
      endcase
    end
    if (s == 6'd3 && !r && i == 9'd0) return 8'h00;
    if (s == 6'd2 && !r && i == 9'd0) return 8'hF0;
    return 8'(int'(s) * 37 + int'(r) * 101 + int'(i) * 13 + 1) ^ 8'h5A;
  endfunction

  always @(posedge sys_clk) font_data <= rom(font_sel, font_row, index);

  function automatic int wmodel(input logic [5:0] cd);
    case (cd)
      6'd0, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11: return 16;
      default: return 8;
    endcase
  endfunction

  task automatic model(input logic [2:0] pg, input logic [6:0] col, input logic [3:0] len, input logic [47:0] codes);
    int n, c, rows;
    logic [5:0] cd;
    n = len > 4'd8 ? 8 : int'(len);
    rows = pg == 3'd7 ? 1 : 2;
    if (n == 0) return;
    for (int r = 0; r < rows; r++) begin
      c = int'(col);
      exp_q.push_back({1'b0, 8'hB0 | 8'(int'(pg) + r)});
      exp_q.push_back({1'b0, 4'h0, col[3:0]});
      exp_q.push_back({1'b0, 5'b00010, col[6:4]});
      for (int k = 0; k < n; k++) begin
        cd = codes[6*k +: 6];
        for (int i = 0; i < wmodel(cd); i++)
          if (c < 128) begin
            exp_q.push_back({1'b1, cd >= 6'd15 ? 8'h00 : rom(cd, r[0], 9'(i))});
            c++;
          end
      end
    end
  endtask

  task automatic start_req(input logic [2:0] pg, input logic [6:0] col, input logic [3:0] len, input logic [47:0] codes);
    @(posedge sys_clk); #1;
    req_page = pg; req_col = col; req_len = len; req_codes = codes;
    req_valid = 1'b1; out_ready = 1'b1;
    model(pg, col, len, codes);
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    req_page = 3'($urandom); req_col = 7'($urandom); req_len = 4'($urandom);
    req_codes = 48'({$urandom(), $urandom()});
  endtask

  task automatic collect(input int max_cyc, input bit rnd);
    logic [15:0] snap;
    logic [24:0] cur, prev;
    bit stalled;
    stalled = 1'b0; prev = '0;
    obs_q.delete(); stall_err = 0; done_cyc = -1; first_valid = -1; font_chg = 1'b0; busy_at_done = 1'b1;
    snap = {font_sel, font_row, index};
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge sys_clk);
      cur = {font_sel, font_row, index, out_dc, out_byte};
      if ({font_sel, font_row, index} != snap) font_chg = 1'b1;
      if (stalled && (!out_valid || cur != prev)) stall_err++;
      if (done) begin
        done_cyc = c; busy_at_done = busy;
        break;
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && out_ready) obs_q.push_back({out_dc, out_byte});
      stalled = out_valid && !out_ready;
      prev = cur;
      @(posedge sys_clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    n_tests++;
    if ({out_valid, out_byte, out_dc, font_sel, font_row, index} !== 26'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {out_valid, out_byte, out_dc, font_sel, font_row, index});
    end
    n_tests++;
    if ({busy, done, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL reset_status: got busy/done/ready %b want 001", {busy, done, req_ready});
    end
    @(posedge sys_clk); #1; rst_n = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_two_rows;
    start_req(3'd2, 7'd0, 4'd1, 48'd0);
    req_valid = 1'b1;
    collect(3000, 1'b0);
    req_valid = 1'b0;
    n_tests++;
    if (first_valid !== 0) begin n_fail++; $display("FAIL two_rows first_valid: got %0d want 0", first_valid); end
    n_tests++;
    if (done_cyc !== 102) begin n_fail++; $display("FAIL two_rows done_cycle: got %0d want 102", done_cyc); end
    n_tests++;
    if (obs_q.size() !== 38) begin n_fail++; $display("FAIL two_rows handshakes: got %0d want 38", obs_q.size()); end
    n_tests++;
    if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL two_rows busy_at_done: got %b want 0", busy_at_done); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL two_rows byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    @(negedge sys_clk);
    n_tests++;
    if ({done, busy, req_ready} !== 3'b001) begin n_fail++; $display("FAIL done_pulse: got done/busy/ready %b want 001", {done, busy, req_ready}); end
  endtask

  task automatic test_page7;
    start_req(3'd7, 7'd4, 4'd2, {36'd0, 6'd2, 6'd3});
    collect(3000, 1'b0);
    n_tests++;
    if (done_cyc !== 51) begin n_fail++; $display("FAIL page7 done_cycle: got %0d want 51", done_cyc); end
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL page7 count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    if (obs_q.size() > 11) begin
      n_tests++;
      if (obs_q[3] !== 9'h100 || obs_q[11] !== 9'h1F0) begin
        n_fail++; $display("FAIL page7 glyph_first: got %h %h want 100 1f0", obs_q[3], obs_q[11]);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL page7 byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clip;
    start_req(3'd0, 7'd120, 4'd2, {36'd0, 6'd1, 6'd0});
    collect(3000, 1'b0);
    n_tests++;
    if (obs_q.size() !== 22) begin n_fail++; $display("FAIL clip count: got %0d want 22", obs_q.size()); end
    n_tests++;
    if (done_cyc !== 54) begin n_fail++; $display("FAIL clip done_cycle: got %0d want 54", done_cyc); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL clip byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall;
    start_req(3'd1, 7'd10, 4'd1, 48'd6);
    collect(4000, 1'b1);
    out_ready = 1'b1;
    n_tests++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL stall timeout: got no done want done"); end
    n_tests++;
    if (stall_err !== 0) begin n_fail++; $display("FAIL stall stability: got %0d changes want 0", stall_err); end
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL stall byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_blank;
    start_req(3'd3, 7'd0, 4'd1, 48'd20);
    collect(3000, 1'b0);
    n_tests++;
    if (font_chg !== 1'b0) begin n_fail++; $display("FAIL blank rom_address: got changed want unchanged"); end
    n_tests++;
    if (done_cyc !== 38) begin n_fail++; $display("FAIL blank done_cycle: got %0d want 38", done_cyc); end
    n_tests++;
    if (obs_q.size() !== 22) begin n_fail++; $display("FAIL blank count: got %0d want 22", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL blank byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_len0;
    start_req(3'd4, 7'd30, 4'd0, 48'd1);
    collect(50, 1'b0);
    n_tests++;
    if (done_cyc !== 0) begin n_fail++; $display("FAIL len0 done_cycle: got %0d want 0", done_cyc); end
    n_tests++;
    if (first_valid !== -1) begin n_fail++; $display("FAIL len0 out_valid: got high at %0d want never", first_valid); end
  endtask

  task automatic test_clamp;
    start_req(3'd0, 7'd0, 4'd15, {6'd13, 6'd12, 6'd3, 6'd2, 6'd10, 6'd14, 6'd13, 6'd12});
    collect(3000, 1'b0);
    n_tests++;
    if (done_cyc !== 390) begin n_fail++; $display("FAIL clamp done_cycle: got %0d want 390", done_cyc); end
    n_tests++;
    if (obs_q.size() !== 134) begin n_fail++; $display("FAIL clamp count: got %0d want 134", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL clamp byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_abort;
    int data_cnt;
    bit hit;
    data_cnt = 0; hit = 1'b0;
    start_req(3'd0, 7'd0, 4'd1, 48'd0);
    exp_q.delete();
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge sys_clk);
      if (out_valid && out_dc) begin
        if (data_cnt == 4) hit = 1'b1;
        else if (out_ready) data_cnt++;
      end
      if (!hit) begin
        @(posedge sys_clk); #1;
        out_ready = data_cnt != 4;
      end
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL abort reach_5th: got %0d data bytes want 4 then stall", data_cnt); end
    rst_n = 1'b0;
    @(posedge sys_clk); #1; rst_n = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if ({out_valid, req_ready, busy, out_byte, font_sel, index} !== {2'b01, 1'b0, 23'd0}) begin
      n_fail++; $display("FAIL abort idle: got valid/ready/busy %b byte %h sel %h idx %h want 010 00 00 000",
                         {out_valid, req_ready, busy}, out_byte, font_sel, index);
    end
    start_req(3'd5, 7'd64, 4'd1, 48'd9);
    collect(3000, 1'b0);
    n_tests++;
    if (done_cyc !== 102) begin n_fail++; $display("FAIL after_abort done_cycle: got %0d want 102", done_cyc); end
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL after_abort count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL after_abort byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    test_reset;
    test_two_rows;
    test_page7;
    test_clip;
    test_stall;
    test_blank;
    test_len0;
    test_clamp;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
